// File: rtl/branch_predict_ctrl.sv
// Branch predictor and misprediction recovery for a 5-stage RISC-V pipeline:
// 2-bit BHT predict at IF, resolve/train at EX, redirect plus timed flush.
module branch_predict_ctrl #(
    parameter int PC_WIDTH     = 32,
    parameter int INST_WIDTH   = 32,
    parameter int BHT_IDX_W    = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic [PC_WIDTH-1:0]   if_pc,
    input  logic [INST_WIDTH-1:0] if_ir,
    output logic                  if_branch_predict,
    input  logic [INST_WIDTH-1:0] idex_ir,
    input  logic [PC_WIDTH-1:0]   idex_pc,
    input  logic [PC_WIDTH-1:0]   idex_target,
    input  logic                  branch_eq_flag,
    output logic                  idex_branch_decision,
    output logic                  redirect_valid,
    output logic [PC_WIDTH-1:0]   redirect_pc,
    output logic                  flush,
    output logic [CNT_W-1:0]      branch_cnt,
    output logic [CNT_W-1:0]      mispredict_cnt
);
    localparam int         ENTRIES   = 1 << BHT_IDX_W;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t               state, state_nxt;
    logic [2:0]           fcnt, fcnt_nxt;
    logic [1:0]           bht [ENTRIES];
    logic                 ifid_pred;
    logic                 resolve, taken, mispredict;
    logic [BHT_IDX_W-1:0] if_idx, ex_idx;

    assign if_idx            = if_pc[BHT_IDX_W+1:2];
    assign ex_idx            = idex_pc[BHT_IDX_W+1:2];
    assign if_branch_predict = (if_ir[6:0] == OP_BRANCH) ? bht[if_idx][1] : 1'b0;

    // Branches reaching EX while flushing are wrong-path and never resolve.
    assign resolve    = (state == RUN) && !stall && (idex_ir[6:0] == OP_BRANCH);
    assign taken      = branch_eq_flag ^ idex_ir[12];
    assign mispredict = taken != idex_branch_decision;
    assign flush      = (state == FLUSH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) bht[i] <= 2'b01;
        end else if (resolve) begin
            if (taken && bht[ex_idx] != 2'b11)
                bht[ex_idx] <= bht[ex_idx] + 2'd1;
            else if (!taken && bht[ex_idx] != 2'b00)
                bht[ex_idx] <= bht[ex_idx] - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifid_pred            <= 1'b0;
            idex_branch_decision <= 1'b0;
        end else if (flush) begin
            ifid_pred            <= 1'b0;
            idex_branch_decision <= 1'b0;
        end else if (!stall) begin
            ifid_pred            <= if_branch_predict;
            idex_branch_decision <= ifid_pred;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            redirect_valid <= resolve && mispredict;
            if (resolve) begin
                if (branch_cnt != '1) branch_cnt <= branch_cnt + CNT_W'(1);
                if (mispredict) begin
                    if (mispredict_cnt != '1) mispredict_cnt <= mispredict_cnt + CNT_W'(1);
                    redirect_pc <= taken ? idex_target : idex_pc + PC_WIDTH'(4);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            fcnt  <= 3'd0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
        end
    end

    // Flush lasts FLUSH_CYCLES cycles and ignores stall.
    always_comb begin
        state_nxt = state;
        fcnt_nxt  = fcnt;
        case (state)
            RUN: if (resolve && mispredict) begin
                state_nxt = FLUSH;
                fcnt_nxt  = 3'(FLUSH_CYCLES - 1);
            end
            FLUSH: if (fcnt == 3'd0) state_nxt = RUN;
                   else fcnt_nxt = fcnt - 3'd1;
            default: state_nxt = RUN;
        endcase
    end
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Self-checking bench for branch_predict_ctrl: reference BHT/counter model,
// expected redirects queued at resolve and compared after the resolve edge.
module tb_branch_predict_ctrl;
    localparam int FC = 2;
    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] BEQ = 32'h00000063;
    localparam logic [31:0] BNE = 32'h00001063;

    typedef struct { logic rv; logic [31:0] pc; } exp_t;

    logic        clk = 0, rst = 0, stall = 0;
    logic [31:0] if_pc = 0, if_ir = NOP, idex_ir = NOP, idex_pc = 0, idex_target = 0;
    logic        branch_eq_flag = 0;
    logic        if_branch_predict, idex_branch_decision, redirect_valid, flush;
    logic [31:0] redirect_pc;
    logic [15:0] branch_cnt, mispredict_cnt;

    int n_cmp = 0, n_err = 0;
    logic [1:0]  bht_m [16];
    logic [15:0] exp_br, exp_mp;
    exp_t        sb [$];

    branch_predict_ctrl #(.PC_WIDTH(32), .INST_WIDTH(32), .BHT_IDX_W(4), .FLUSH_CYCLES(FC), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .stall(stall), .if_pc(if_pc), .if_ir(if_ir),
        .if_branch_predict(if_branch_predict), .idex_ir(idex_ir), .idex_pc(idex_pc),
        .idex_target(idex_target), .branch_eq_flag(branch_eq_flag),
        .idex_branch_decision(idex_branch_decision), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .flush(flush), .branch_cnt(branch_cnt),
        .mispredict_cnt(mispredict_cnt));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int i = 0; i < 16; i++) bht_m[i] = 2'b01;
        exp_br = 0; exp_mp = 0;
        sb.delete();
    endtask

    task automatic test_reset();
        rst = 1; if_pc = 32'h40; if_ir = BEQ;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL rst_rv: got %b exp 0", redirect_valid); end
        n_cmp++; if (redirect_pc !== 32'h0) begin n_err++; $display("FAIL rst_rpc: got %h exp 0", redirect_pc); end
        n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL rst_flush: got %b exp 0", flush); end
        n_cmp++; if (branch_cnt !== 16'h0 || mispredict_cnt !== 16'h0) begin n_err++; $display("FAIL rst_cnt: got %h/%h exp 0/0", branch_cnt, mispredict_cnt); end
        n_cmp++; if (idex_branch_decision !== 1'b0) begin n_err++; $display("FAIL rst_dec: got %b exp 0", idex_branch_decision); end
        n_cmp++; if (if_branch_predict !== 1'b0) begin n_err++; $display("FAIL rst_pred: got %b exp 0", if_branch_predict); end
        @(negedge clk); rst = 0; if_ir = NOP;
    endtask

    // One branch: IF, ID, then EX with optional stall, squash-during-flush or reset-mid-flush.
    task automatic run_branch(input logic [31:0] pc, input logic [31:0] ir, input logic [31:0] tgt,
                              input logic eq, input int stall_cyc, input bit squash, input bit rst_mid);
        logic p, tk, mp;
        int   idx;
        exp_t e, got;
        idx = int'(pc[5:2]);
        @(negedge clk); if_pc = pc; if_ir = ir; idex_ir = NOP;
        p = bht_m[idx][1];
        #1;
        n_cmp++; if (if_branch_predict !== p) begin n_err++; $display("FAIL predict pc=%h: got %b exp %b", pc, if_branch_predict, p); end
        @(negedge clk); if_ir = NOP;
        @(negedge clk); idex_ir = ir; idex_pc = pc; idex_target = tgt; branch_eq_flag = eq;
        #1;
        n_cmp++; if (idex_branch_decision !== p) begin n_err++; $display("FAIL ex_decision pc=%h: got %b exp %b", pc, idex_branch_decision, p); end
        for (int s = 0; s < stall_cyc; s++) begin
            stall = 1;
            @(posedge clk); #1;
            n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL stall_rv: got %b exp 0", redirect_valid); end
            n_cmp++; if (branch_cnt !== exp_br || mispredict_cnt !== exp_mp) begin n_err++; $display("FAIL stall_cnt: got %h/%h exp %h/%h", branch_cnt, mispredict_cnt, exp_br, exp_mp); end
            @(negedge clk);
        end
        stall = 0;
        tk = eq ^ ir[12];
        mp = (tk != p);
        e.rv = mp; e.pc = tk ? tgt : pc + 32'd4;
        sb.push_back(e);
        if (exp_br != 16'hFFFF) exp_br++;
        if (mp && exp_mp != 16'hFFFF) exp_mp++;
        if (tk && bht_m[idx] != 2'b11) bht_m[idx]++;
        else if (!tk && bht_m[idx] != 2'b00) bht_m[idx]--;
        @(posedge clk); #1;
        got = sb.pop_front();
        n_cmp++; if (redirect_valid !== got.rv) begin n_err++; $display("FAIL redirect_valid pc=%h: got %b exp %b", pc, redirect_valid, got.rv); end
        if (got.rv) begin
            n_cmp++; if (redirect_pc !== got.pc) begin n_err++; $display("FAIL redirect_pc pc=%h: got %h exp %h", pc, redirect_pc, got.pc); end
        end
        n_cmp++; if (branch_cnt !== exp_br || mispredict_cnt !== exp_mp) begin n_err++; $display("FAIL counters pc=%h: got %h/%h exp %h/%h", pc, branch_cnt, mispredict_cnt, exp_br, exp_mp); end
        n_cmp++; if (flush !== mp) begin n_err++; $display("FAIL flush_start pc=%h: got %b exp %b", pc, flush, mp); end
        if (mp && rst_mid) begin
            rst = 1; #1;
            model_reset();
            n_cmp++; if (flush !== 1'b0 || redirect_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid: flush=%b rv=%b exp 0/0", flush, redirect_valid); end
            n_cmp++; if (branch_cnt !== 16'h0 || mispredict_cnt !== 16'h0) begin n_err++; $display("FAIL rst_mid_cnt: got %h/%h exp 0/0", branch_cnt, mispredict_cnt); end
            @(negedge clk); rst = 0; idex_ir = NOP;
            return;
        end
        if (mp) begin
            for (int k = 1; k <= FC; k++) begin
                @(negedge clk);
                if (squash) begin idex_ir = BEQ; branch_eq_flag = ~branch_eq_flag; end
                else idex_ir = NOP;
                @(posedge clk); #1;
                n_cmp++; if (flush !== (k < FC)) begin n_err++; $display("FAIL flush_len k=%0d: got %b exp %b", k, flush, (k < FC)); end
                n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL flush_rv k=%0d: got %b exp 0", k, redirect_valid); end
                n_cmp++; if (branch_cnt !== exp_br || mispredict_cnt !== exp_mp) begin n_err++; $display("FAIL flush_cnt k=%0d: got %h/%h exp %h/%h", k, branch_cnt, mispredict_cnt, exp_br, exp_mp); end
            end
        end
        @(negedge clk); idex_ir = NOP;
    endtask

    task automatic test_first_mispredict();
        run_branch(32'h40, BEQ, 32'h80, 1'b1, 0, 0, 0);
    endtask

    task automatic test_train_saturate();
        run_branch(32'h40, BEQ, 32'h80, 1'b1, 0, 0, 0);
        run_branch(32'h40, BEQ, 32'h80, 1'b1, 0, 0, 0);
        run_branch(32'h40, BEQ, 32'h80, 1'b0, 0, 0, 0);
        run_branch(32'h40, BEQ, 32'h80, 1'b1, 0, 0, 0);
    endtask

    task automatic test_bne();
        run_branch(32'h44, BNE, 32'h90, 1'b1, 0, 0, 0);
        run_branch(32'h44, BNE, 32'h90, 1'b0, 0, 0, 0);
        run_branch(32'h44, BNE, 32'h90, 1'b0, 0, 0, 0);
    endtask

    task automatic test_wrap();
        run_branch(32'hFFFFFFFC, BEQ, 32'h100, 1'b1, 0, 0, 0);
        run_branch(32'hFFFFFFFC, BEQ, 32'h100, 1'b0, 0, 0, 0);
    endtask

    task automatic test_stall();
        run_branch(32'h48, BEQ, 32'hA0, 1'b1, 3, 0, 0);
    endtask

    task automatic test_flush_squash();
        run_branch(32'h4C, BEQ, 32'hB0, 1'b1, 0, 1, 0);
        run_branch(32'h4C, BEQ, 32'hB0, 1'b1, 0, 0, 0);
    endtask

    task automatic test_reset_mid_flush();
        run_branch(32'h50, BEQ, 32'hC0, 1'b1, 0, 0, 1);
        run_branch(32'h40, BEQ, 32'h80, 1'b0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_first_mispredict();
        test_train_saturate();
        test_bne();
        test_wrap();
        test_stall();
        test_flush_squash();
        test_reset_mid_flush();
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d exp 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
